// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking of digit_en when LEAD_ZERO_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow,
    output logic [DIGITS-1:0]   digit_en
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q;
    logic [SW-1:0] work_q;
    logic [SW-1:0] adj_d;
    logic [SW-1:0] work_d;
    logic [CW-1:0] cnt_q;
    logic          ovf_acc_q;
    logic          ovf_d;
    logic          busy_q;
    logic          done_q;
    logic [BW-1:0] bcd_q;
    logic          ovf_q;
    logic          last_d;

    // BCD field sits above the binary bits; bits leaving the top digit
    // would belong to digits we do not have, hence the overflow flag.
    always_comb begin
        adj_d = work_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (work_q[WIDTH+4*k +: 4] >= 4'd5) begin
                adj_d[WIDTH+4*k +: 4] = work_q[WIDTH+4*k +: 4] + 4'd3;
            end
        end
        work_d = {adj_d[SW-2:0], 1'b0};
        ovf_d  = ovf_acc_q | adj_d[SW-1];
    end

    assign last_d = (state_q == SHIFT) && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q    <= {{BW{1'b0}}, bin};
                        cnt_q     <= CW'(WIDTH);
                        ovf_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q    <= work_d;
                    ovf_acc_q <= ovf_d;
                    cnt_q     <= cnt_q - CW'(1);
                    if (last_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= work_d[WIDTH +: BW];
                        ovf_q   <= ovf_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic [DIGITS-1:0] en_d;
    logic [DIGITS-1:0] en_q;
    logic              nz;

    always_comb begin
        en_d = '1;
        nz   = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz      = nz | (work_d[WIDTH+4*k +: 4] != 4'd0);
            en_d[k] = nz;
        end
        en_d[0] = 1'b1;
        if (ovf_d) begin
            en_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= '1;
        end else if (last_d) begin
            en_q <= en_d;
        end
    end

    assign digit_en = en_q;
`else
    assign digit_en = '1;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule
